pmu_wr_responder: RTL and testbench
===================================

Name: pmu_wr_responder

Overview:
- PMU-side responder of the four-phase req/ack register-write handshake issued from the system (HCLK) domain toward the always-on PMU domain.
- Runs entirely on the PMU reference clock.
- Synchronizes the incoming request, captures the quasi-static register bundle (scratch, PMU trigger, PMU mode) into shadow registers, and returns ack.
- Shadows are output as the restore values read back by the APB side after wake-up; trigger and mode-change pulses go to the wake-up controller.

Parameters:
SYNC_STAGES, 2, synchronizer depth on req_i; legal values 2..4.
DATA_WIDTH, 32, width of the scratch and mode registers.
CNT_WIDTH, 8, width of the completed-write counter.

Ports:
clk_i  in  1  PMU reference clock.
rst_i  in  1  synchronous active-high reset.
req_i  in  1  write request from the system domain; asynchronous; registered glitch-free at source.
scratch_i  in  DATA_WIDTH  scratch value; stable while req_i=1.
pmu_en_i  in  1  trigger bit; stable while req_i=1.
pmu_mode_i  in  DATA_WIDTH  mode value; stable while req_i=1.
hold_i  in  1  blocks acceptance of new requests.
ack_o  out  1  acknowledge back to the system domain; registered.
scratch_o  out  DATA_WIDTH  shadow scratch (restore value).
pmu_mode_o  out  DATA_WIDTH  shadow mode (restore value).
pmu_en_o  out  1  shadow trigger bit.
trig_o  out  1  one-cycle pulse: write completed with pmu_en_i=1.
mode_chg_o  out  1  one-cycle pulse: captured mode differs from previous shadow.
wr_cnt_o  out  CNT_WIDTH  number of completed writes; wraps.
busy_o  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (rst_i=1 at an edge):
  - sync chain, shadows, wr_cnt_o cleared to 0;
  - ack_o, trig_o, mode_chg_o, busy_o = 0;
  - state = IDLE.
  - This applies mid-transaction too: ack_o is low after that edge, and no capture takes place.
- Synchronizer: req_s is the last of SYNC_STAGES flops; no edge detection on raw req_i.
- FSM, states IDLE, CAPTURE, ACK:
  - IDLE: ack_o=0. If req_s=1 and hold_i=0, go to CAPTURE. If req_s=1 and hold_i=1, stay in IDLE until hold_i=0.
  - CAPTURE (exactly one cycle), on exit:
    - load scratch_o<=scratch_i, pmu_mode_o<=pmu_mode_i, pmu_en_o<=pmu_en_i;
    - wr_cnt_o<=wr_cnt_o+1 (modulo 2^CNT_WIDTH);
    - trig_o<=pmu_en_i;
    - mode_chg_o<=(pmu_mode_i!=pmu_mode_o);
    - go to ACK.
  - ACK: ack_o=1 (registered, equal to state==ACK). Stay while req_s=1. When req_s=0, go to IDLE.
- hold_i only gates the IDLE->CAPTURE transition. A transaction already in CAPTURE or ACK completes regardless of hold_i.
- Latency with SYNC_STAGES=2, counting edge E0 as the first edge that samples req_i=1:
  - CAPTURE is entered at E2;
  - shadows load, trig_o/mode_chg_o go high and ack_o goes high at E3;
  - the pulses clear at E4.
- Release latency with SYNC_STAGES=2, counting En as the first edge that samples req_i=0: ack_o falls at En+2.
- General latency: rise takes SYNC_STAGES+1 edges; fall takes SYNC_STAGES edges.
- Back-to-back requests: a new req_s=1 seen in IDLE is accepted the cycle after ack_o falls. No minimum gap is required.
- req_i falling before ack_o rises is a protocol violation and is not specially handled. The capture still completes, then ack_o rises and drops as soon as req_s=0.
- Data inputs are not synchronized. They are sampled only in CAPTURE, which guarantees at least SYNC_STAGES cycles of stability.
- Pulses: trig_o and mode_chg_o are high for exactly one cycle per transaction, never in consecutive cycles.
- busy_o = (state != IDLE).

Test Plan:
1. Reset then single write (scratch=32'hCAFE0001, mode=32'h3, en=0) -> ack_o high at E3, scratch_o=32'hCAFE0001, pmu_mode_o=3, mode_chg_o one pulse, trig_o=0, wr_cnt_o=1; req_i drops -> ack_o low 2 edges later.
2. Two writes with the same mode=32'h3, second with en=1 -> second write gives trig_o one pulse and mode_chg_o=0; wr_cnt_o=2; pmu_en_o=1.
3. hold_i=1 while req_i=1 for 10 cycles -> ack_o stays 0 and shadows are unchanged. Release hold_i -> CAPTURE next cycle, ack_o high one cycle after that.
4. rst_i asserted while in ACK -> ack_o=0, all shadows=0, wr_cnt_o=0 after that edge. req_i still high after rst_i deasserts -> a fresh transaction is captured.
5. 256 back-to-back writes -> wr_cnt_o wraps to 0. Each write produces exactly one ack_o high phase, with no ack_o rise before req_s rises.
6. SYNC_STAGES=3 -> ack_o rises 4 edges after req_i is sampled high and falls 3 edges after req_i is sampled low.

Source files
------------

// File: rtl/pmu_wr_responder.sv
// PMU-side responder for the four-phase req/ack register-write handshake.
// Synchronizes req_i, captures the register bundle into shadows and returns ack.
module pmu_wr_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] scratch_i,
  input  logic                  pmu_en_i,
  input  logic [DATA_WIDTH-1:0] pmu_mode_i,
  input  logic                  hold_i,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] scratch_o,
  output logic [DATA_WIDTH-1:0] pmu_mode_o,
  output logic                  pmu_en_o,
  output logic                  trig_o,
  output logic                  mode_chg_o,
  output logic [CNT_WIDTH-1:0]  wr_cnt_o,
  output logic                  busy_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("pmu_wr_responder: SYNC_STAGES must be 2..4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    req_s;
  logic                    ack_q;
  logic                    busy_q;
  logic                    trig_q;
  logic                    mode_chg_q;
  logic                    pmu_en_q;
  logic [DATA_WIDTH-1:0]   scratch_q;
  logic [DATA_WIDTH-1:0]   pmu_mode_q;
  logic [CNT_WIDTH-1:0]    wr_cnt_q;

  // Request synchronizer; only the last stage is ever used.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Handshake FSM; ack/busy are registered alongside the state they reflect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      trig_q     <= 1'b0;
      mode_chg_q <= 1'b0;
      pmu_en_q   <= 1'b0;
      scratch_q  <= '0;
      pmu_mode_q <= '0;
      wr_cnt_q   <= '0;
    end else begin
      trig_q     <= 1'b0;
      mode_chg_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_s && !hold_i) begin
            state_q <= CAPTURE;
            busy_q  <= 1'b1;
          end
        end
        CAPTURE: begin
          // Data inputs have been stable for at least SYNC_STAGES cycles here.
          scratch_q  <= scratch_i;
          pmu_mode_q <= pmu_mode_i;
          pmu_en_q   <= pmu_en_i;
          wr_cnt_q   <= wr_cnt_q + CNT_WIDTH'(1);
          trig_q     <= pmu_en_i;
          mode_chg_q <= (pmu_mode_i != pmu_mode_q);
          state_q    <= ACK;
          ack_q      <= 1'b1;
        end
        ACK: begin
          if (!req_s) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_o      = ack_q;
  assign busy_o     = busy_q;
  assign trig_o     = trig_q;
  assign mode_chg_o = mode_chg_q;
  assign pmu_en_o   = pmu_en_q;
  assign scratch_o  = scratch_q;
  assign pmu_mode_o = pmu_mode_q;
  assign wr_cnt_o   = wr_cnt_q;

endmodule

// File: tb/tb_pmu_wr_responder.sv
// Scoreboard bench for pmu_wr_responder: expected captures are queued at issue
// time and checked by a monitor on every ack_o rise.
module tb_pmu_wr_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] scratch;
  logic        en;
  logic [31:0] mode;
  logic        hold;

  logic        ack, pmu_en, trig, mode_chg, busy;
  logic [31:0] scratch_o, mode_o;
  logic [7:0]  cnt;

  logic        ack3, pmu_en3, trig3, mode_chg3, busy3;
  logic [31:0] scratch3, mode3;
  logic [7:0]  cnt3;

  always #5 clk = ~clk;

  pmu_wr_responder #(.SYNC_STAGES(2), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .scratch_i(scratch), .pmu_en_i(en),
    .pmu_mode_i(mode), .hold_i(hold), .ack_o(ack), .scratch_o(scratch_o),
    .pmu_mode_o(mode_o), .pmu_en_o(pmu_en), .trig_o(trig), .mode_chg_o(mode_chg),
    .wr_cnt_o(cnt), .busy_o(busy)
  );

  pmu_wr_responder #(.SYNC_STAGES(3), .DATA_WIDTH(32), .CNT_WIDTH(8)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .scratch_i(scratch), .pmu_en_i(en),
    .pmu_mode_i(mode), .hold_i(hold), .ack_o(ack3), .scratch_o(scratch3),
    .pmu_mode_o(mode3), .pmu_en_o(pmu_en3), .trig_o(trig3), .mode_chg_o(mode_chg3),
    .wr_cnt_o(cnt3), .busy_o(busy3)
  );

  typedef struct {
    logic [31:0] scr;
    logic [31:0] mode;
    logic        en;
    logic        trig;
    logic        mchg;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model of the shadow state
  logic [31:0] m_scr, m_mode;
  logic        m_en;
  logic [7:0]  m_cnt;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endfunction

  function automatic void model_reset();
    m_scr = '0; m_mode = '0; m_en = 1'b0; m_cnt = '0;
  endfunction

  function automatic void push_exp(input logic [31:0] s, input logic [31:0] md,
                                   input logic e);
    exp_t x;
    x.scr  = s;
    x.mode = md;
    x.en   = e;
    x.trig = e;
    x.mchg = (md != m_mode);
    x.cnt  = m_cnt + 8'd1;
    m_scr = s; m_mode = md; m_en = e; m_cnt = x.cnt;
    sb_q.push_back(x);
  endfunction

  // Monitor: pop on each ack rise; also pulses must never last two cycles.
  logic ack_prev = 1'b0, trig_prev = 1'b0, mchg_prev = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (ack === 1'b1 && ack_prev === 1'b0) begin
      check("ack_rise_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        x = sb_q.pop_front();
        check("scratch_o", scratch_o, x.scr);
        check("pmu_mode_o", mode_o, x.mode);
        check("pmu_en_o", 32'(pmu_en), 32'(x.en));
        check("trig_o", 32'(trig), 32'(x.trig));
        check("mode_chg_o", 32'(mode_chg), 32'(x.mchg));
        check("wr_cnt_o", 32'(cnt), 32'(x.cnt));
      end
    end
    if (trig_prev === 1'b1) check("trig_one_cycle", 32'(trig), 32'd0);
    if (mchg_prev === 1'b1) check("mode_chg_one_cycle", 32'(mode_chg), 32'd0);
    ack_prev  = ack;
    trig_prev = trig;
    mchg_prev = mode_chg;
  end

  // Wait until both instances show ack==lvl; latencies in edges after the first.
  task automatic wait_both(input logic lvl, output int l2, output int l3);
    l2 = -1; l3 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack == lvl && l2 < 0) l2 = n - 1;
      if (ack3 == lvl && l3 < 0) l3 = n - 1;
      if (l2 >= 0 && l3 >= 0) break;
    end
    if (l2 < 0 || l3 < 0) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  int r2, r3, f2, f3;

  task automatic do_write(input logic [31:0] s, input logic [31:0] md, input logic e);
    push_exp(s, md, e);
    @(negedge clk);
    scratch = s; mode = md; en = e; req = 1'b1;
    wait_both(1'b1, r2, r3);
    req = 1'b0;
    wait_both(1'b0, f2, f3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int d2, d3;

  initial begin
    rst = 1'b1; req = 1'b0; scratch = '0; en = 1'b0; mode = '0; hold = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_scratch", scratch_o, 32'd0);
    check("rst_mode", mode_o, 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_trig", 32'(trig), 32'd0);
    rst = 1'b0;

    // 1: single write, latency measured on the 2-stage instance
    do_write(32'hCAFE0001, 32'h3, 1'b0);
    check("t1_rise_latency", 32'(r2), 32'd3);
    check("t1_fall_latency", 32'(f2), 32'd2);

    // 2: same mode, en=1 -> trig pulse, no mode change
    do_write(32'hCAFE0002, 32'h3, 1'b1);
    check("t2_cnt", 32'(cnt), 32'd2);
    check("t2_pmu_en", 32'(pmu_en), 32'd1);

    // 3: hold blocks acceptance
    @(negedge clk);
    hold = 1'b1; scratch = 32'h0000BEEF; mode = 32'h7; en = 1'b0; req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t3_hold_ack", 32'(ack), 32'd0);
    end
    check("t3_hold_busy", 32'(busy), 32'd0);
    check("t3_hold_scratch", scratch_o, m_scr);
    check("t3_hold_cnt", 32'(cnt), 32'(m_cnt));
    push_exp(32'h0000BEEF, 32'h7, 1'b0);
    hold = 1'b0;
    @(negedge clk);
    check("t3_capture_busy", 32'(busy), 32'd1);
    check("t3_capture_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("t3_ack_after", 32'(ack), 32'd1);
    wait_both(1'b1, d2, d3);
    req = 1'b0;
    wait_both(1'b0, d2, d3);

    // 4: reset while in ACK, request still high afterwards
    push_exp(32'h12345678, 32'h5, 1'b1);
    @(negedge clk);
    scratch = 32'h12345678; mode = 32'h5; en = 1'b1; req = 1'b1;
    wait_both(1'b1, d2, d3);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_ack", 32'(ack), 32'd0);
    check("t4_rst_scratch", scratch_o, 32'd0);
    check("t4_rst_mode", mode_o, 32'd0);
    check("t4_rst_en", 32'(pmu_en), 32'd0);
    check("t4_rst_cnt", 32'(cnt), 32'd0);
    model_reset();
    push_exp(32'h12345678, 32'h5, 1'b1);
    rst = 1'b0;
    wait_both(1'b1, d2, d3);
    check("t4_fresh_cnt", 32'(cnt), 32'd1);
    req = 1'b0;
    wait_both(1'b0, d2, d3);

    // 5: 256 back-to-back writes from a clean counter wrap to 0
    do_reset();
    for (int i = 0; i < 256; i++)
      do_write(32'h1000 + 32'(i), 32'(i % 4), 1'(i % 2));
    check("t5_wrap_cnt", 32'(cnt), 32'd0);

    // 6: 3-stage synchronizer latency
    do_write(32'hA5A5A5A5, 32'h9, 1'b0);
    check("t6_rise_latency", 32'(r3), 32'd4);
    check("t6_fall_latency", 32'(f3), 32'd3);
    check("t6_rise_latency_2stage", 32'(r2), 32'd3);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
